seg7_scroll_mux: RTL
====================

Name: seg7_scroll_mux

Overview:
- Next-generation 7-segment display driver.
- Drives NUM_DIGITS time-multiplexed common digits from one shared segment bus.
- Modes: scroll a fixed glyph message across the digits, show a free-running hex counter, freeze, or blank.
- Sits between the top-level wrapper and the output pins; replaces the single-digit combinational decoder.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- MSG_LEN, 10, glyph count of the message ROM (2..16).
- PRESCALE_W, 16, width of the scroll-period input and prescaler.
- MUX_W, 10, width of the digit-refresh counter; digit advances every 2^MUX_W cycles.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  scroll/count enable; low stalls the prescaler only.
- mode  in  2  0=scroll, 1=hex counter, 2=freeze, 3=blank.
- step_div  in  PRESCALE_W  scroll period minus 1, in clk cycles.
- segments  out  7  bit0=top(1) .. bit5=upper-left(6), bit6=middle(7); active-high.
- digit_sel  out  NUM_DIGITS  one-hot active-high; bit0 is the leftmost digit.
- position  out  $clog2(MSG_LEN)  current message offset.
- wrap  out  1  one-cycle pulse on sequence wrap.

Behaviour:
- Reset (async, rst_n=0): all outputs and counters are 0. segments=0, digit_sel=0, position=0, wrap=0, prescaler=0, mux counter=0, digit index=0, hex count=0.
- Prescaler: counts 0..step_div when ena=1 and mode is 0 or 1.
  - tick = (count==step_div); count then returns to 0.
  - step_div=0 gives a tick every cycle.
  - ena=0, or mode 2 or 3, holds count.
  - If step_div is lowered below count, count continues to wrap at its maximum, then behaves normally.
- Scroll (mode 0), on each tick: position = (position==MSG_LEN-1) ? 0 : position+1.
  - wrap=1 on the cycle after a MSG_LEN-1 -> 0 transition.
- Hex (mode 1), on each tick: hex count (4*NUM_DIGITS bits) increments, wrapping naturally.
  - wrap pulses when the count wraps all-ones -> 0.
- position and hex count are each retained across mode changes; they are never cleared except by reset.
- Mux counter: free-runs in every mode, independent of ena.
  - On overflow, digit index = (idx==NUM_DIGITS-1) ? 0 : idx+1.
- Output registers update every cycle from the current digit index, so segments and digit_sel are always mutually consistent.
  - First clk edge after reset release: digit_sel=1, segments = glyph for digit 0.
  - digit_sel = 1<<idx in modes 0-2; all zero in mode 3.
- Glyph per digit k:
  - mode 0: MSG[(position+k) mod MSG_LEN].
  - mode 1: HEX[nibble NUM_DIGITS-1-k], MSB leftmost.
  - mode 2: the glyph from the last active mode, with position and count held.
  - mode 3: segments=0.
- MSG ROM (index 0..9): d, E, F, A, U, L, t, 1, 2, 3. Codes (bit6..bit0): 1011110, 1111001, 1110001, 1110111, 0111110, 0111000, 1111000, 0000110, 1011011, 1001111. Entries at index MSG_LEN and above show 0111111.
- HEX ROM: standard 0-F. Example codes: 0=0111111, 8=1111111, F=1110001.
- Simultaneous tick and mode change: the tick is evaluated with the mode value of that cycle.
- Reset mid-scroll: immediate return to reset values; no partial frame is held.

Optional Feature:
- Macro: SEG7_BOUNCE_EN.
- Defined: scroll mode ping-pongs. position increments to MSG_LEN-NUM_DIGITS, then decrements to 0, then repeats.
  - wrap pulses at each reversal.
  - A direction flag resets to "up".
  - If MSG_LEN <= NUM_DIGITS, position stays 0.
- Undefined: circular scroll as described in Behaviour; no direction flag is instantiated.

Decomposition:
- Package seg7_pkg holds:
  - glyph_t (7-bit logic);
  - mode_e enum (MODE_SCROLL, MODE_HEX, MODE_FREEZE, MODE_BLANK);
  - the MSG and HEX glyph constant arrays;
  - GLYPH_DEFAULT = 0111111.
- One sub-module, seg7_glyph_rom: combinational; inputs are a select bit (msg/hex) and a 4-bit index; output is a glyph_t. One instance is shared by all digits.

Test Plan:
- Reset with rst_n=0 asserted mid-run, asynchronously (no clk edge) -> all outputs 0 immediately. Release -> first edge gives digit_sel=0001, segments=1011110.
- mode=0, step_div=3, ena=1 -> position advances every 4 cycles. 9 -> 0 transition produces exactly one wrap pulse. With position=8, digit 2 shows 'd' (1011110).
- mode=0, ena toggled low for 7 cycles -> position frozen and prescaler holds. Digit scanning continues at a 2^MUX_W-cycle cadence (MUX_W=3 in test).
- mode=1, step_div=0 -> count increments every cycle. After 0xFFFF -> 0x0000, wrap=1 for one cycle. At count=0x8F00, digit 0 shows 1111111 and digit 1 shows 1110001.
- mode=3, then mode=0 -> mode 3 gives digit_sel=0 and segments=0. Returning to mode 0 resumes at the retained position.
- SEG7_BOUNCE_EN defined, MSG_LEN=10, NUM_DIGITS=4 -> position sequence 0..6, 5..0, 1.. with wrap pulses at 6 and 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and glyph tables for the seg7_scroll_mux display driver.
package seg7_pkg;

    typedef logic [6:0] glyph_t;

    typedef enum logic [1:0] {
        MODE_SCROLL = 2'd0,
        MODE_HEX    = 2'd1,
        MODE_FREEZE = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_e;

    localparam glyph_t GLYPH_DEFAULT = 7'b0111111;

    localparam int MSG_ROM_LEN = 10;

    // Message "dEFAULt123", bit6 = middle .. bit0 = top
    localparam glyph_t MSG_ROM [MSG_ROM_LEN] = '{
        7'b1011110, 7'b1111001, 7'b1110001, 7'b1110111, 7'b0111110,
        7'b0111000, 7'b1111000, 7'b0000110, 7'b1011011, 7'b1001111
    };

    localparam glyph_t HEX_ROM [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph lookup shared by all digits: message ROM or hex ROM.
module seg7_glyph_rom
    import seg7_pkg::*;
#(
    parameter int MSG_LEN = 10
) (
    input  logic       sel_hex,
    input  logic [3:0] idx,
    output glyph_t     glyph
);

    always_comb begin
        glyph = GLYPH_DEFAULT;
        if (sel_hex) begin
            glyph = HEX_ROM[idx];
        end else if (int'(idx) < MSG_LEN && int'(idx) < MSG_ROM_LEN) begin
            glyph = MSG_ROM[idx];
        end
    end

endmodule

// File: rtl/seg7_scroll_mux.sv
// Multiplexed 7-segment driver: scrolling message, hex counter, freeze, blank.
// Define SEG7_BOUNCE_EN to make scroll mode ping-pong instead of wrapping.
module seg7_scroll_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_LEN    = 10,
    parameter int PRESCALE_W = 16,
    parameter int MUX_W      = 10,
    localparam int POS_W     = $clog2(MSG_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] step_div,
    output logic [6:0]            segments,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [POS_W-1:0]      position,
    output logic                  wrap
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int HEX_W = 4 * NUM_DIGITS;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(MSG_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    mode_e                 cur_mode;
    mode_e                 last_mode;
    mode_e                 glyph_mode;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [MUX_W-1:0]      mux_cnt;
    logic [IDX_W-1:0]      dig_idx;
    logic [IDX_W-1:0]      dig_rev;
    logic [HEX_W-1:0]      hex_cnt;
    logic                  active;
    logic                  tick;
    logic                  scroll_tick;
    logic                  hex_tick;
    logic [POS_W-1:0]      pos_nxt;
    logic                  wrap_nxt;
    logic [5:0]            msg_sum;
    logic                  sel_hex;
    logic [3:0]            rom_idx;
    glyph_t                rom_glyph;

    assign cur_mode    = mode_e'(mode);
    assign active      = ena && (cur_mode == MODE_SCROLL || cur_mode == MODE_HEX);
    assign tick        = active && (pre_cnt == step_div);
    assign scroll_tick = tick && (cur_mode == MODE_SCROLL);
    assign hex_tick    = tick && (cur_mode == MODE_HEX);

`ifdef SEG7_BOUNCE_EN
    localparam int BOUNCE_TOP = (MSG_LEN > NUM_DIGITS) ? MSG_LEN - NUM_DIGITS : 0;

    logic dir_up;
    logic dir_nxt;
`endif

    always_comb begin
        pos_nxt  = position;
        wrap_nxt = 1'b0;
`ifdef SEG7_BOUNCE_EN
        dir_nxt  = dir_up;
        if (scroll_tick && BOUNCE_TOP != 0) begin
            // Reversal is flagged on the step that lands on an end point
            if (dir_up) begin
                pos_nxt = position + 1'b1;
                if (pos_nxt == POS_W'(BOUNCE_TOP)) begin
                    dir_nxt  = 1'b0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                pos_nxt = position - 1'b1;
                if (pos_nxt == '0) begin
                    dir_nxt  = 1'b1;
                    wrap_nxt = 1'b1;
                end
            end
        end
`else
        if (scroll_tick) begin
            if (position == POS_LAST) begin
                pos_nxt  = '0;
                wrap_nxt = 1'b1;
            end else begin
                pos_nxt = position + 1'b1;
            end
        end
`endif
        if (hex_tick && (&hex_cnt)) begin
            wrap_nxt = 1'b1;
        end
    end

    // Freeze keeps rendering whichever content mode was last live
    always_comb begin
        glyph_mode = (cur_mode == MODE_FREEZE) ? last_mode : cur_mode;
        sel_hex    = (glyph_mode == MODE_HEX);
        dig_rev    = IDX_LAST - dig_idx;
        msg_sum    = 6'(position) + 6'(dig_idx);
        for (int unsigned i = 0; i < 8; i++) begin
            if (msg_sum >= 6'(MSG_LEN)) begin
                msg_sum = msg_sum - 6'(MSG_LEN);
            end
        end
        rom_idx = sel_hex ? 4'(hex_cnt >> {dig_rev, 2'b00}) : 4'(msg_sum);
    end

    seg7_glyph_rom #(
        .MSG_LEN (MSG_LEN)
    ) u_rom (
        .sel_hex (sel_hex),
        .idx     (rom_idx),
        .glyph   (rom_glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            mux_cnt   <= '0;
            dig_idx   <= '0;
            hex_cnt   <= '0;
            position  <= '0;
            wrap      <= 1'b0;
            last_mode <= MODE_SCROLL;
            segments  <= '0;
            digit_sel <= '0;
        end else begin
            if (active) begin
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            end
            if (hex_tick) begin
                hex_cnt <= hex_cnt + 1'b1;
            end
            if (cur_mode == MODE_SCROLL || cur_mode == MODE_HEX) begin
                last_mode <= cur_mode;
            end
            position <= pos_nxt;
            wrap     <= wrap_nxt;

            mux_cnt <= mux_cnt + 1'b1;
            if (&mux_cnt) begin
                dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
            end

            if (cur_mode == MODE_BLANK) begin
                segments  <= '0;
                digit_sel <= '0;
            end else begin
                segments  <= rom_glyph;
                digit_sel <= NUM_DIGITS'(1) << dig_idx;
            end
        end
    end

`ifdef SEG7_BOUNCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_up <= 1'b1;
        end else begin
            dir_up <= dir_nxt;
        end
    end
`endif

endmodule
